ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 187 ++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 lines, frames Set 2 bytes and
// decodes a small key set to ASCII with typematic and break-code handling.
module ps2_key_decoder #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keyout,
   output logic       key_update,
   output logic       frame_err
);

   localparam int unsigned TW = ($clog2(TIMEOUT_CYCLES + 1) > 16) ? $clog2(TIMEOUT_CYCLES + 1) : 16;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [1:0]    clk_sync, dat_sync;
   logic          clk_prev;
   logic          fall, dat;

   state_t        state, state_nxt;
   logic [3:0]    bit_cnt, bit_cnt_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          parity, parity_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic          byte_vld, byte_vld_nxt;
   logic [7:0]    rx_byte, rx_byte_nxt;
   logic          err_nxt;

   logic          brk, brk_nxt, ext, ext_nxt;
   logic          held_vld, held_vld_nxt;
   logic [7:0]    held, held_nxt;
   logic [7:0]    key_nxt;
   logic          ku_nxt;
   logic [8:0]    map_c;

   assign fall = clk_prev & ~clk_sync[1];
   assign dat  = dat_sync[1];

   // Set 2 make code to ASCII; bit 8 flags a mapped code
   function automatic logic [8:0] map_code(input logic [7:0] sc);
      case (sc)
         8'h32:   map_code = {1'b1, 8'h42};
         8'h23:   map_code = {1'b1, 8'h44};
         8'h24:   map_code = {1'b1, 8'h45};
         8'h2B:   map_code = {1'b1, 8'h46};
         8'h2D:   map_code = {1'b1, 8'h52};
         default: map_code = 9'h000;
      endcase
   endfunction

   assign map_c = map_code(rx_byte);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         clk_sync   <= 2'b11;
         dat_sync   <= 2'b11;
         clk_prev   <= 1'b1;
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         shift      <= 8'h00;
         parity     <= 1'b0;
         tcnt       <= '0;
         byte_vld   <= 1'b0;
         rx_byte    <= 8'h00;
         frame_err  <= 1'b0;
         brk        <= 1'b0;
         ext        <= 1'b0;
         held_vld   <= 1'b0;
         held       <= 8'h00;
         keyout     <= 8'h00;
         key_update <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk};
         dat_sync   <= {dat_sync[0], ps2_data};
         clk_prev   <= clk_sync[1];
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         shift      <= shift_nxt;
         parity     <= parity_nxt;
         tcnt       <= tcnt_nxt;
         byte_vld   <= byte_vld_nxt;
         rx_byte    <= rx_byte_nxt;
         frame_err  <= err_nxt;
         brk        <= brk_nxt;
         ext        <= ext_nxt;
         held_vld   <= held_vld_nxt;
         held       <= held_nxt;
         keyout     <= key_nxt;
         key_update <= ku_nxt;
      end
   end

   // Frame receiver; the timeout takes priority over a stalled partial frame
   always_comb begin
      state_nxt    = state;
      bit_cnt_nxt  = bit_cnt;
      shift_nxt    = shift;
      parity_nxt   = parity;
      tcnt_nxt     = tcnt;
      byte_vld_nxt = 1'b0;
      rx_byte_nxt  = rx_byte;
      err_nxt      = 1'b0;

      if (fall) begin
         tcnt_nxt = '0;
      end else if (state != IDLE) begin
         tcnt_nxt = tcnt + TW'(1);
      end

      if (state != IDLE && !fall && tcnt == T_LAST) begin
         err_nxt     = 1'b1;
         state_nxt   = IDLE;
         bit_cnt_nxt = 4'd0;
         shift_nxt   = 8'h00;
         tcnt_nxt    = '0;
      end else if (fall) begin
         case (state)
            IDLE: begin
               if (!dat) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = 4'd0;
                  shift_nxt   = 8'h00;
               end
            end
            DATA: begin
               shift_nxt = {dat, shift[7:1]};
               if (bit_cnt == 4'd7) begin
                  state_nxt   = PARITY;
                  bit_cnt_nxt = 4'd0;
               end else begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end
            PARITY: begin
               parity_nxt = dat;
               state_nxt  = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (dat && (^{shift, parity})) begin
                  byte_vld_nxt = 1'b1;
                  rx_byte_nxt  = shift;
               end else begin
                  err_nxt = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Key decode: prefix flags apply to the next non-prefix byte only
   always_comb begin
      brk_nxt      = brk;
      ext_nxt      = ext;
      held_vld_nxt = held_vld;
      held_nxt     = held;
      key_nxt      = keyout;
      ku_nxt       = 1'b0;

      if (byte_vld) begin
         if (rx_byte == 8'hF0) begin
            brk_nxt = 1'b1;
         end else if (rx_byte == 8'hE0) begin
            ext_nxt = 1'b1;
         end else begin
            brk_nxt = 1'b0;
            ext_nxt = 1'b0;
            if (brk) begin
               if (held_vld && rx_byte == held) begin
                  held_vld_nxt = 1'b0;
               end
            end else if (!ext && map_c[8] && (!held_vld || rx_byte != held)) begin
               key_nxt      = map_c[7:0];
               ku_nxt       = 1'b1;
               held_vld_nxt = 1'b1;
               held_nxt     = rx_byte;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized PS/2 frame stimulus checked every cycle against a byte-level key model,
// plus directed scenarios with literal expectations.
module tb_ps2_key_decoder;

   localparam int unsigned TO = 200;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] keyout;
   logic       key_update;
   logic       frame_err;

   ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .keyout(keyout), .key_update(key_update), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_seen = 1'b0;
   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= !reset_n;
   end

   // Reference model state (owned by the stimulus process)
   logic       m_brk = 1'b0, m_ext = 1'b0, m_held_v = 1'b0;
   logic [7:0] m_held = 8'h00, m_key = 8'h00, ku_val = 8'h00;
   int         ku_due = -1, err_lo = -1, err_hi = -1, last_fall = 0;

   // Counters owned by the compare process
   int   n_cmp = 0, n_bad = 0, ku_count = 0, err_count = 0;
   logic err_seen = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [8:0] ascii_of(input logic [7:0] sc);
      case (sc)
         8'h32:   return {1'b1, 8'h42};
         8'h23:   return {1'b1, 8'h44};
         8'h24:   return {1'b1, 8'h45};
         8'h2B:   return {1'b1, 8'h46};
         8'h2D:   return {1'b1, 8'h52};
         default: return 9'h000;
      endcase
   endfunction

   always @(negedge clk) begin
      logic in_win;
      if (rst_seen) begin
         check("rst_keyout", 32'(keyout), 32'h00);
         check("rst_key_update", 32'(key_update), 32'h0);
         check("rst_frame_err", 32'(frame_err), 32'h0);
      end else begin
         check("key_update", 32'(key_update), 32'(ku_due >= 0 && cyc == ku_due));
         check("keyout", 32'(keyout), 32'((ku_due >= 0 && cyc >= ku_due) ? ku_val : m_key));
         in_win = (err_lo >= 0 && cyc >= err_lo && cyc <= err_hi);
         if (!in_win) begin
            check("frame_err", 32'(frame_err), 32'h0);
         end else begin
            if (frame_err) begin
               check("frame_err_once", 32'(err_seen), 32'h0);
               err_seen = 1'b1;
            end
            if (cyc == err_hi) begin
               check("frame_err_window", 32'(err_seen), 32'h1);
               err_seen = 1'b0;
            end
         end
         check("exclusive", 32'(key_update & frame_err), 32'h0);
         if (key_update) ku_count++;
         if (frame_err) err_count++;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      wait_cyc(int'($urandom_range(3, 8)));
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(int'($urandom_range(3, 8)));
      ps2_clk = 1'b1;
   endtask

   // Decoded-byte rules; c is the cycle the stop bit fell
   task automatic model_byte(input logic [7:0] b, input int c);
      logic [8:0] a;
      a = ascii_of(b);
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else begin
         if (m_brk) begin
            if (m_held_v && m_held == b) m_held_v = 1'b0;
         end else if (!m_ext && a[8] && (!m_held_v || m_held != b)) begin
            if (ku_due >= 0) m_key = ku_val;
            ku_due   = c + 4;
            ku_val   = a[7:0];
            m_held   = b;
            m_held_v = 1'b1;
         end
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      int c;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(~(^b) ^ bad_par);
      ps2_data = ~bad_stop;
      wait_cyc(int'($urandom_range(3, 8)));
      ps2_clk = 1'b0;
      c = cyc;
      if (bad_par || bad_stop) begin
         err_lo = c + 3;
         err_hi = c + 3;
      end else begin
         model_byte(b, c);
      end
      wait_cyc(int'($urandom_range(3, 8)));
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      wait_cyc(int'($urandom_range(4, 12)));
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      ps2_bit(1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
      err_lo   = last_fall + int'(TO);
      err_hi   = last_fall + int'(TO) + 6;
      ps2_data = 1'b1;
      wait_cyc(int'(TO) + 20);
   endtask

   task automatic glitch_edge();
      ps2_data = 1'b1;
      wait_cyc(4);
      ps2_clk = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b1;
      wait_cyc(8);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      wait_cyc(1);
      m_key    = 8'h00;
      m_held_v = 1'b0;
      m_brk    = 1'b0;
      m_ext    = 1'b0;
      ku_due   = -1;
      err_lo   = -1;
      reset_n  = 1'b1;
      wait_cyc(5);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int k0, e0;
      logic [7:0] pool [10];
      pool = '{8'h32, 8'h23, 8'h24, 8'h2B, 8'h2D, 8'hF0, 8'hF0, 8'hE0, 8'h1C, 8'h00};
      wait_cyc(3);
      reset_n = 1'b1;
      wait_cyc(5);
      check("reset_keyout", 32'(keyout), 32'h00);

      k0 = ku_count; e0 = err_count;
      send_frame(8'h32, 1'b0, 1'b0);
      check("r029_keyout", 32'(keyout), 32'h42);
      check("r029_pulses", 32'(ku_count - k0), 32'd1);
      check("r029_err", 32'(err_count - e0), 32'd0);

      k0 = ku_count;
      repeat (3) send_frame(8'h24, 1'b0, 1'b0);
      check("r030_typematic_keyout", 32'(keyout), 32'h45);
      check("r030_typematic_pulses", 32'(ku_count - k0), 32'd1);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h24, 1'b0, 1'b0);
      send_frame(8'h24, 1'b0, 1'b0);
      check("r030_repress_pulses", 32'(ku_count - k0), 32'd2);
      check("r030_repress_keyout", 32'(keyout), 32'h45);

      k0 = ku_count; e0 = err_count;
      send_frame(8'h2D, 1'b1, 1'b0);
      check("r031_err", 32'(err_count - e0), 32'd1);
      check("r031_keyout", 32'(keyout), 32'h45);
      check("r031_pulses", 32'(ku_count - k0), 32'd0);

      e0 = err_count;
      send_partial(8'h5A, 4);
      check("r032_timeout_err", 32'(err_count - e0), 32'd1);
      send_frame(8'h2B, 1'b0, 1'b0);
      check("r032_keyout", 32'(keyout), 32'h46);

      k0 = ku_count; e0 = err_count;
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h32, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h23, 1'b0, 1'b0);
      check("r033_pulses", 32'(ku_count - k0), 32'd0);
      check("r033_err", 32'(err_count - e0), 32'd0);
      check("r033_keyout", 32'(keyout), 32'h46);

      k0 = ku_count;
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) begin
         logic [7:0] v;
         v = 8'h23;
         ps2_bit(v[i]);
      end
      wait_cyc(3);
      do_reset();
      check("r034_reset_keyout", 32'(keyout), 32'h00);
      send_frame(8'h23, 1'b0, 1'b0);
      check("r034_pulses", 32'(ku_count - k0), 32'd1);
      check("r034_keyout", 32'(keyout), 32'h44);

      glitch_edge();
      check("glitch_keyout", 32'(keyout), 32'h44);

      for (int n = 0; n < 150; n++) begin
         int r;
         logic [7:0] b;
         r = int'($urandom_range(0, 19));
         b = pool[$urandom_range(0, 9)];
         if (b == 8'h00) b = 8'($urandom);
         if (r == 0) glitch_edge();
         else if (r == 1) send_frame(b, 1'b1, 1'b0);
         else if (r == 2) send_frame(b, 1'b0, 1'b1);
         else send_frame(b, 1'b0, 1'b0);
      end

      wait_cyc(20);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
